// File: rtl/board_state_ctrl.sv
// Board register and move sequencer for the 2048 game: commits a changed candidate
// board, spawns a 2/4 tile in a pseudo-random empty cell, then evaluates win/lose.
module board_state_ctrl #(
   parameter logic [11:0] WIN_VALUE = 12'd2048,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  move_req,
   input  logic [1:0]            move_dir,
   input  logic [3:0][3:0][11:0] moved_board,
   output logic [1:0]            dir_sel,
   output logic [3:0][3:0][11:0] board,
   output logic                  busy,
   output logic                  done,
   output logic                  changed,
   output logic                  won,
   output logic                  lost
);

   typedef enum logic [2:0] {
      S_INIT_SPAWN,
      S_IDLE,
      S_SELECT,
      S_COMPARE,
      S_COMMIT,
      S_SPAWN,
      S_CHECK
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic [3:0]  ptr;
   logic        init_second;

   logic        probe_empty;
   logic [11:0] spawn_val;
   logic        board_same;
   logic        win_hit;
   logic        has_empty;
   logic        pair_eq;

   logic        latch_dir;
   logic        commit;
   logic        load_ptr;
   logic        ptr_inc;
   logic        spawn_wr;
   logic        check_en;
   logic        set_second;
   logic        done_nx;
   logic        changed_nx;

   // Taps 16,14,13,11 of the Fibonacci polynomial, shifting towards the MSB.
   assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign probe_empty = (board[ptr[3:2]][ptr[1:0]] == 12'd0);
   assign spawn_val   = (lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;
   assign board_same  = (moved_board == board);
   assign busy        = (state != S_IDLE);

   always_comb begin : scan
      win_hit   = 1'b0;
      has_empty = 1'b0;
      pair_eq   = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board[r][c] == WIN_VALUE) win_hit = 1'b1;
            if (board[r][c] == 12'd0) has_empty = 1'b1;
         end
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (board[r][c] == board[r][c+1]) pair_eq = 1'b1;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board[r][c] == board[r+1][c]) pair_eq = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_INIT_SPAWN;
      else      state <= state_nx;
   end

   always_comb begin : fsm_next
      state_nx   = state;
      latch_dir  = 1'b0;
      commit     = 1'b0;
      load_ptr   = 1'b0;
      ptr_inc    = 1'b0;
      spawn_wr   = 1'b0;
      check_en   = 1'b0;
      set_second = 1'b0;
      done_nx    = 1'b0;
      changed_nx = 1'b0;
      case (state)
         S_INIT_SPAWN: begin
            // The second spawn restarts from a fresh pointer; the tile just
            // written is no longer empty, so the two tiles are always distinct.
            if (probe_empty) begin
               spawn_wr = 1'b1;
               if (init_second) begin
                  state_nx = S_IDLE;
               end else begin
                  set_second = 1'b1;
                  load_ptr   = 1'b1;
               end
            end else begin
               ptr_inc = 1'b1;
            end
         end
         S_IDLE: begin
            if (move_req && !won && !lost) begin
               latch_dir = 1'b1;
               state_nx  = S_SELECT;
            end
         end
         S_SELECT: state_nx = S_COMPARE;
         S_COMPARE: begin
            if (board_same) begin
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_COMMIT;
            end
         end
         S_COMMIT: begin
            commit   = 1'b1;
            load_ptr = 1'b1;
            state_nx = S_SPAWN;
         end
         S_SPAWN: begin
            if (probe_empty) begin
               spawn_wr = 1'b1;
               state_nx = S_CHECK;
            end else begin
               ptr_inc = 1'b1;
            end
         end
         S_CHECK: begin
            check_en   = 1'b1;
            done_nx    = 1'b1;
            changed_nx = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_INIT_SPAWN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr        <= LFSR_SEED;
         ptr         <= LFSR_SEED[3:0];
         init_second <= 1'b0;
         dir_sel     <= 2'b00;
         board       <= '0;
         done        <= 1'b0;
         changed     <= 1'b0;
         won         <= 1'b0;
         lost        <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         if (latch_dir) dir_sel <= move_dir;
         if (set_second) init_second <= 1'b1;
         if (load_ptr)     ptr <= lfsr[3:0];
         else if (ptr_inc) ptr <= ptr + 4'd1;
         if (commit)        board <= moved_board;
         else if (spawn_wr) board[ptr[3:2]][ptr[1:0]] <= spawn_val;
         done <= done_nx;
         if (done_nx) changed <= changed_nx;
         if (check_en) begin
            won  <= won | win_hit;
            lost <= lost | (!has_empty && !pair_eq);
         end
      end
   end

endmodule

// File: tb/tb_board_state_ctrl.sv
// Directed bench for board_state_ctrl: reset, initial spawn, no-change and changing
// moves, dropped requests, reset during spawn, win and lose detection.
module tb_board_state_ctrl;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  move_req;
   logic [1:0]            move_dir;
   logic [3:0][3:0][11:0] moved_board;
   logic [1:0]            dir_sel;
   logic [3:0][3:0][11:0] board;
   logic                  busy;
   logic                  done;
   logic                  changed;
   logic                  won;
   logic                  lost;

   int n_cmp = 0;
   int n_bad = 0;

   board_state_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .move_req    (move_req),
      .move_dir    (move_dir),
      .moved_board (moved_board),
      .dir_sel     (dir_sel),
      .board       (board),
      .busy        (busy),
      .done        (done),
      .changed     (changed),
      .won         (won),
      .lost        (lost)
   );

   always #5 clk = ~clk;

   function automatic int count_nonzero(input logic [3:0][3:0][11:0] b);
      int n;
      n = 0;
      for (int p = 0; p < 16; p++) if (b[p/4][p%4] != 12'd0) n++;
      return n;
   endfunction

   function automatic int count_bad_tiles(input logic [3:0][3:0][11:0] b);
      int n;
      n = 0;
      for (int p = 0; p < 16; p++)
         if (b[p/4][p%4] != 12'd0 && b[p/4][p%4] != 12'd2 && b[p/4][p%4] != 12'd4) n++;
      return n;
   endfunction

   task automatic start_move(input logic [1:0] dir);
      @(negedge clk);
      move_req = 1'b1;
      move_dir = dir;
      @(posedge clk);
      #1;
      move_req = 1'b0;
   endtask

   task automatic wait_idle(output int ndone, output logic last_chg, output logic timeout);
      ndone    = 0;
      last_chg = 1'b0;
      timeout  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            last_chg = changed;
         end
         if (!busy) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst         = 1'b1;
      move_req    = 1'b0;
      move_dir    = 2'b00;
      moved_board = '0;
      #3 rst = 1'b0;
      #1;
      n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL reset_board: got %h want 0", board); end
      n_cmp++; if (dir_sel !== 2'b00) begin n_bad++; $display("FAIL reset_dir_sel: got %b want 00", dir_sel); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL reset_changed: got %b want 0", changed); end
      n_cmp++; if (won !== 1'b0) begin n_bad++; $display("FAIL reset_won: got %b want 0", won); end
      n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost: got %b want 0", lost); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL reset_hold_board: got %h want 0", board); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_init_spawn;
      int   nd;
      logic chg;
      logic to;
      wait_idle(nd, chg, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL init_timeout: busy got %b want 0 within 40 cycles", busy); end
      n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL init_done: got %0d pulses want 0", nd); end
      n_cmp++; if (count_nonzero(board) !== 2) begin n_bad++; $display("FAIL init_tiles: got %0d tiles want 2", count_nonzero(board)); end
      n_cmp++; if (count_bad_tiles(board) !== 0) begin n_bad++; $display("FAIL init_values: got %0d tiles not 2/4 want 0", count_bad_tiles(board)); end
      n_cmp++; if ({won, lost} !== 2'b00) begin n_bad++; $display("FAIL init_flags: won/lost got %b want 00", {won, lost}); end
   endtask

   task automatic test_no_change;
      logic [3:0][3:0][11:0] snap;
      @(negedge clk);
      snap        = board;
      moved_board = board;
      start_move(2'b10);
      n_cmp++; if (dir_sel !== 2'b10) begin n_bad++; $display("FAIL nochg_dir_sel: got %b want 10", dir_sel); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nochg_busy: got %b want 1", busy); end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL nochg_done_early: got %b want 0", done); end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL nochg_done: got %b want 1", done); end
      n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL nochg_changed: got %b want 0", changed); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nochg_idle: busy got %b want 0", busy); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL nochg_done_len: got %b want 0", done); end
      n_cmp++; if (board !== snap) begin n_bad++; $display("FAIL nochg_board: got %h want %h", board, snap); end
      n_cmp++; if (dir_sel !== 2'b10) begin n_bad++; $display("FAIL nochg_dir_hold: got %b want 10", dir_sel); end
   endtask

   task automatic test_commit_cell9;
      logic [3:0][3:0][11:0] snap;
      logic [3:0][3:0][11:0] exp;
      int   nd;
      int   ndiff;
      logic chg;
      logic to;
      logic ok;
      @(negedge clk);
      snap = board;
      for (int p = 0; p < 16; p++) exp[p/4][p%4] = 12'd8;
      exp[2][1]   = 12'd0;
      moved_board = exp;
      start_move(2'b01);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (board !== snap) begin n_bad++; $display("FAIL c9_board_early: got %h want %h", board, snap); end
      @(posedge clk);
      #1;
      n_cmp++; if (board !== exp) begin n_bad++; $display("FAIL c9_commit: got %h want %h", board, exp); end
      wait_idle(nd, chg, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL c9_timeout: busy got %b want 0", busy); end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL c9_done: got %0d pulses want 1", nd); end
      n_cmp++; if (chg !== 1'b1) begin n_bad++; $display("FAIL c9_changed: got %b want 1", chg); end
      ndiff = 0;
      for (int p = 0; p < 16; p++) if (p != 9 && board[p/4][p%4] != 12'd8) ndiff++;
      n_cmp++; if (ndiff !== 0) begin n_bad++; $display("FAIL c9_others: got %0d cells changed want 0", ndiff); end
      ok = (board[2][1] == 12'd2) || (board[2][1] == 12'd4);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL c9_spawn: cell 9 got %0d want 2 or 4", board[2][1]); end
      n_cmp++; if ({won, lost} !== 2'b00) begin n_bad++; $display("FAIL c9_flags: won/lost got %b want 00", {won, lost}); end
   endtask

   task automatic test_back_to_back;
      logic [3:0][3:0][11:0] exp;
      int   nd;
      int   total;
      int   extra_done;
      int   extra_busy;
      logic chg;
      logic to;
      @(negedge clk);
      exp         = '0;
      exp[0][0]   = 12'd16;
      moved_board = exp;
      start_move(2'b11);
      repeat (3) @(posedge clk);
      #1;
      move_req = 1'b1;
      move_dir = 2'b00;
      @(posedge clk);
      #1;
      move_req = 1'b0;
      total = done ? 1 : 0;
      wait_idle(nd, chg, to);
      total += nd;
      extra_done = 0;
      extra_busy = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done) extra_done++;
         if (busy) extra_busy++;
      end
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout: busy got %b want 0", busy); end
      n_cmp++; if (total !== 1) begin n_bad++; $display("FAIL b2b_done: got %0d pulses want 1", total); end
      n_cmp++; if (extra_done !== 0) begin n_bad++; $display("FAIL b2b_queued_done: got %0d want 0", extra_done); end
      n_cmp++; if (extra_busy !== 0) begin n_bad++; $display("FAIL b2b_queued_busy: got %0d busy cycles want 0", extra_busy); end
      n_cmp++; if (board[0][0] !== 12'd16) begin n_bad++; $display("FAIL b2b_cell0: got %0d want 16", board[0][0]); end
      n_cmp++; if (count_nonzero(board) !== 2) begin n_bad++; $display("FAIL b2b_tiles: got %0d want 2", count_nonzero(board)); end
      n_cmp++; if (dir_sel !== 2'b11) begin n_bad++; $display("FAIL b2b_dir_sel: got %b want 11", dir_sel); end
   endtask

   task automatic test_reset_mid_spawn;
      logic [3:0][3:0][11:0] exp;
      @(negedge clk);
      exp         = '0;
      exp[0][0]   = 12'd32;
      moved_board = exp;
      start_move(2'b01);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (board !== exp) begin n_bad++; $display("FAIL rms_commit: got %h want %h", board, exp); end
      rst = 1'b0;
      #1;
      n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL rms_board: got %h want 0", board); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rms_busy: got %b want 1", busy); end
      n_cmp++; if (dir_sel !== 2'b00) begin n_bad++; $display("FAIL rms_dir_sel: got %b want 00", dir_sel); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL rms_board_hold: got %h want 0", board); end
      @(negedge clk);
      rst = 1'b1;
      test_init_spawn();
   endtask

   task automatic test_won;
      logic [3:0][3:0][11:0] exp;
      int   nd;
      int   busy_cnt;
      logic chg;
      logic to;
      @(negedge clk);
      exp         = '0;
      exp[1][1]   = 12'd2048;
      moved_board = exp;
      start_move(2'b01);
      wait_idle(nd, chg, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL won_timeout: busy got %b want 0", busy); end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL won_done: got %0d pulses want 1", nd); end
      n_cmp++; if (chg !== 1'b1) begin n_bad++; $display("FAIL won_changed: got %b want 1", chg); end
      n_cmp++; if (won !== 1'b1) begin n_bad++; $display("FAIL won_flag: got %b want 1", won); end
      n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL won_lost: got %b want 0", lost); end
      @(negedge clk);
      moved_board = '0;
      start_move(2'b10);
      busy_cnt = busy ? 1 : 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (busy) busy_cnt++;
      end
      n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL won_drop: got %0d busy cycles want 0", busy_cnt); end
      n_cmp++; if (dir_sel !== 2'b01) begin n_bad++; $display("FAIL won_dir_sel: got %b want 01", dir_sel); end
   endtask

   task automatic test_lost;
      logic [3:0][3:0][11:0] exp;
      int   nd;
      int   ndiff;
      logic chg;
      logic to;
      logic ok;
      logic exp_lost;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      test_init_spawn();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            exp[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
      exp[0][0]   = 12'd0;
      moved_board = exp;
      start_move(2'b00);
      wait_idle(nd, chg, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL lost_timeout: busy got %b want 0", busy); end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL lost_done: got %0d pulses want 1", nd); end
      ndiff = 0;
      for (int p = 1; p < 16; p++) if (board[p/4][p%4] != exp[p/4][p%4]) ndiff++;
      n_cmp++; if (ndiff !== 0) begin n_bad++; $display("FAIL lost_others: got %0d cells changed want 0", ndiff); end
      ok = (board[0][0] == 12'd2) || (board[0][0] == 12'd4);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL lost_spawn: cell 0 got %0d want 2 or 4", board[0][0]); end
      // Both neighbours of cell 0 hold 4: a spawned 2 leaves no merge anywhere.
      exp_lost = (board[0][0] == 12'd2);
      n_cmp++; if (lost !== exp_lost) begin n_bad++; $display("FAIL lost_flag: got %b want %b", lost, exp_lost); end
      n_cmp++; if (won !== 1'b0) begin n_bad++; $display("FAIL lost_won: got %b want 0", won); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init_spawn();
      test_no_change();
      test_commit_cell9();
      test_back_to_back();
      test_reset_mid_spawn();
      test_won();
      test_lost();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
